// File: rtl/matvec_ctrl.sv
// Control sequencer for an MxN matrix-vector multiply: loads W then x from a
// stream, walks each row through the MAC and presents one result per row.
module matvec_ctrl #(
  parameter int M      = 3,
  parameter int N      = 3,
  parameter int RD_LAT = 1,
  localparam int WAW = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int XAW = (N > 1) ? $clog2(N) : 1,
  localparam int RAW = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           input_valid,
  output logic           input_ready,
  output logic           output_valid,
  input  logic           output_ready,
  output logic           w_wr_en,
  output logic [WAW-1:0] w_addr,
  output logic           x_wr_en,
  output logic [XAW-1:0] x_addr,
  output logic           mac_clr,
  output logic           mac_en,
  output logic [RAW-1:0] row_idx
);

  typedef enum logic [2:0] {LOAD_W, LOAD_X, COMPUTE, DRAIN, WAIT_OUT} state_t;
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  localparam logic [WAW-1:0] K_LAST = WAW'(M * N - 1);
  localparam logic [XAW-1:0] X_LAST = XAW'(N - 1);
  localparam logic [RAW-1:0] R_LAST = RAW'(M - 1);

  state_t                state_q, state_d;
  logic [WAW-1:0]        k_q, k_d;
  logic [XAW-1:0]        c_q, c_d, col_q, col_d;
  logic [RAW-1:0]        row_q, row_d;
  tag_t [RD_LAT-1:0]     tag_q, tag_d;
  tag_t                  push, tag_out;
  logic                  accept;

  assign tag_out      = tag_q[RD_LAT-1];
  assign input_ready  = !reset && (state_q == LOAD_W || state_q == LOAD_X);
  assign accept       = input_valid && input_ready;
  assign output_valid = !reset && (state_q == WAIT_OUT);
  assign mac_en       = !reset && tag_out.vld;
  assign mac_clr      = mac_en && tag_out.first;
  assign row_idx      = row_q;

  // k is the weight write counter during load and, since rows are stored
  // row-major, doubles as the running read address during compute.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    col_d   = col_q;
    row_d   = row_q;
    push    = '0;
    w_wr_en = 1'b0;
    x_wr_en = 1'b0;
    w_addr  = '0;
    x_addr  = '0;
    case (state_q)
      LOAD_W: begin
        w_addr = k_q;
        if (accept) begin
          w_wr_en = 1'b1;
          k_d     = k_q + 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = LOAD_X;
          end
        end
      end
      LOAD_X: begin
        x_addr = c_q;
        if (accept) begin
          x_wr_en = 1'b1;
          c_d     = c_q + 1'b1;
          if (c_q == X_LAST) begin
            c_d     = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        w_addr     = k_q;
        x_addr     = col_q;
        push.vld   = 1'b1;
        push.first = (col_q == '0);
        push.last  = (col_q == X_LAST);
        k_d        = k_q + 1'b1;
        col_d      = col_q + 1'b1;
        if (col_q == X_LAST) begin
          col_d   = '0;
          state_d = DRAIN;
          if (row_q == R_LAST) k_d = '0;
        end
      end
      DRAIN: begin
        if (tag_out.vld && tag_out.last) state_d = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (output_ready) begin
          if (row_q == R_LAST) begin
            row_d   = '0;
            state_d = LOAD_W;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD_W;
    endcase
  end

  // Tags travel alongside the memory read so MAC strobes line up with data.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = push;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_W;
      k_q     <= '0;
      c_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_matvec_ctrl.sv
// Bench for matvec_ctrl: two configurations, each wrapped with a simple memory
// and MAC model so the controller's strobes produce real dot products.
module tb_matvec_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- configuration A: M=3 N=3 RD_LAT=1 ----------------
  logic       a_rst, a_iv, a_ir, a_ov, a_ordy, a_wwe, a_xwe, a_clr, a_en;
  logic [3:0] a_wa;
  logic [1:0] a_xa, a_row;
  int         a_din;
  int         a_wm[16];
  int         a_xm[4];
  int         a_pp, a_acc;

  matvec_ctrl #(.M(3), .N(3), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(a_rst), .input_valid(a_iv), .input_ready(a_ir),
    .output_valid(a_ov), .output_ready(a_ordy), .w_wr_en(a_wwe), .w_addr(a_wa),
    .x_wr_en(a_xwe), .x_addr(a_xa), .mac_clr(a_clr), .mac_en(a_en), .row_idx(a_row)
  );

  always @(posedge clk) begin
    if (a_wwe) a_wm[a_wa] <= a_din;
    if (a_xwe) a_xm[a_xa] <= a_din;
    a_pp <= a_wm[a_wa] * a_xm[a_xa];
    if (a_en) a_acc <= a_clr ? a_pp : a_acc + a_pp;
  end

  // ---------------- configuration B: M=2 N=4 RD_LAT=3 ----------------
  logic       b_rst, b_iv, b_ir, b_ov, b_ordy, b_wwe, b_xwe, b_clr, b_en;
  logic [2:0] b_wa;
  logic [1:0] b_xa;
  logic [0:0] b_row;
  int         b_din;
  int         b_wm[8];
  int         b_xm[4];
  int         b_pp[3];
  int         b_acc;

  matvec_ctrl #(.M(2), .N(4), .RD_LAT(3)) u_dut_b (
    .clk(clk), .reset(b_rst), .input_valid(b_iv), .input_ready(b_ir),
    .output_valid(b_ov), .output_ready(b_ordy), .w_wr_en(b_wwe), .w_addr(b_wa),
    .x_wr_en(b_xwe), .x_addr(b_xa), .mac_clr(b_clr), .mac_en(b_en), .row_idx(b_row)
  );

  always @(posedge clk) begin
    if (b_wwe) b_wm[b_wa] <= b_din;
    if (b_xwe) b_xm[b_xa] <= b_din;
    b_pp[0] <= b_wm[b_wa] * b_xm[b_xa];
    b_pp[1] <= b_pp[0];
    b_pp[2] <= b_pp[1];
    if (b_en) b_acc <= b_clr ? b_pp[2] : b_acc + b_pp[2];
  end

  // Reference: y[r] = sum over c of W[r][c] * x[c]
  function automatic int dot_a(input int w[9], input int x[3], input int r);
    int s = 0;
    for (int c = 0; c < 3; c++) s += w[r*3+c] * x[c];
    return s;
  endfunction

  typedef struct {
    int w[9];
    int x[3];
    int y[3];
    bit rnd;
  } vec_t;

  // One complete job on A; optional stall holds output_ready low on row 0.
  task automatic job_a(input int w[9], input int x[3], input bit rnd, input int stall,
                       output int res[3], output int got, output int lat,
                       output int nw, output int nx, output int viol, output int held);
    int words[12];
    int idx = 0, cyc = 0, tx = -1, tov = -1, acc0;
    logic [1:0] r0;
    for (int i = 0; i < 9; i++) words[i] = w[i];
    for (int i = 0; i < 3; i++) words[9+i] = x[i];
    res = '{0, 0, 0};
    got = 0; nw = 0; nx = 0; viol = 0; held = 0;
    while (got < 3 && cyc < 3000) begin
      a_iv   = (idx < 12) && (!rnd || $urandom_range(1, 0) == 1);
      a_din  = (idx < 12) ? words[idx] : 0;
      a_ordy = (stall > 0) ? 1'b0 : (!rnd || $urandom_range(1, 0) == 1);
      @(negedge clk);
      if (a_wwe) nw++;
      if (a_xwe) nx++;
      if (!a_iv && (a_wwe || a_xwe)) viol++;
      if (a_ov && a_en) viol++;
      if (a_xwe && a_xa == 2'd2) tx = cyc;
      if (a_ov && tov < 0) tov = cyc;
      if (a_iv && a_ir) idx++;
      if (a_ov && a_ordy) begin
        res[got] = a_acc;
        got++;
      end
      if (a_ov && stall > 0) begin
        r0 = a_row;
        acc0 = a_acc;
        repeat (stall) begin
          @(posedge clk); #1;
          @(negedge clk);
          cyc++;
          if (a_ov && !a_en && a_row == r0 && a_acc == acc0) held++;
        end
        stall = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_iv = 1'b0;
    a_ordy = 1'b0;
    lat = (tx >= 0 && tov >= 0) ? tov - tx - 1 : -1;
  endtask

  vec_t tbl[4];
  int   res[3];
  int   got, lat, nw, nx, viol, held;
  int   rw[9], rx[3];
  int   cnt_ov, cnt_ir;
  int   bw[8], bx[4], bres[2], ovc[2];
  int   idx, nres, cyc, tx, ne, cb, novc, e;

  initial begin
    a_rst = 1'b1; a_iv = 1'b0; a_ordy = 1'b0; a_din = 0;
    b_rst = 1'b1; b_iv = 1'b0; b_ordy = 1'b0; b_din = 0;

    tbl[0].w = '{10, -20, 30, 50, -60, 70, 80, 100, -110};
    tbl[0].x = '{40, 30, -20};
    tbl[0].y = '{-800, -1200, 8400};
    tbl[0].rnd = 1'b0;
    tbl[1] = tbl[0];
    tbl[1].rnd = 1'b1;
    tbl[2].w = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[2].x = '{5, -7, 9};
    tbl[2].y = '{5, -7, 9};
    tbl[2].rnd = 1'b0;
    tbl[3].w = '{-1, -2, -3, 4, 5, 6, 0, 0, 7};
    tbl[3].x = '{3, -1, 2};
    tbl[3].y = '{-7, 19, 14};
    tbl[3].rnd = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", int'({a_ir, a_ov, a_wwe, a_xwe, a_clr, a_en}), 0);
    chk("reset_row", int'(a_row), 0);
    a_rst = 1'b0;
    #1;
    chk("post_reset_ready", int'(a_ir), 1);

    for (int t = 0; t < 4; t++) begin
      job_a(tbl[t].w, tbl[t].x, tbl[t].rnd, 0, res, got, lat, nw, nx, viol, held);
      chk($sformatf("tbl%0d_nres", t), got, 3);
      for (int r = 0; r < 3; r++) chk($sformatf("tbl%0d_y%0d", t, r), res[r], tbl[t].y[r]);
      chk($sformatf("tbl%0d_wcnt", t), nw, 9);
      chk($sformatf("tbl%0d_xcnt", t), nx, 3);
      chk($sformatf("tbl%0d_viol", t), viol, 0);
      chk($sformatf("tbl%0d_lat", t), lat, 4);
    end

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 9; i++) rw[i] = int'($urandom_range(200)) - 100;
      for (int i = 0; i < 3; i++) rx[i] = int'($urandom_range(200)) - 100;
      job_a(rw, rx, 1'b1, 0, res, got, lat, nw, nx, viol, held);
      chk($sformatf("rnd%0d_nres", t), got, 3);
      for (int r = 0; r < 3; r++) chk($sformatf("rnd%0d_y%0d", t, r), res[r], dot_a(rw, rx, r));
      chk($sformatf("rnd%0d_viol", t), viol, 0);
    end

    job_a(tbl[0].w, tbl[0].x, 1'b0, 20, res, got, lat, nw, nx, viol, held);
    chk("stall_held", held, 20);
    for (int r = 0; r < 3; r++) chk($sformatf("stall_y%0d", r), res[r], tbl[0].y[r]);

    for (int i = 0; i < 5; i++) begin
      a_iv = 1'b1; a_din = 7;
      @(posedge clk); #1;
    end
    a_rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flags", int'({a_ir, a_ov, a_wwe, a_xwe, a_clr, a_en}), 0);
    chk("midrst_row", int'(a_row), 0);
    a_rst = 1'b0;
    #1;
    chk("midrst_ready", int'(a_ir), 1);
    chk("midrst_wwe", int'(a_wwe), 1);
    chk("midrst_waddr", int'(a_wa), 0);
    job_a(tbl[3].w, tbl[3].x, 1'b0, 0, res, got, lat, nw, nx, viol, held);
    chk("midrst_nres", got, 3);
    for (int r = 0; r < 3; r++) chk($sformatf("midrst_y%0d", r), res[r], tbl[3].y[r]);

    cnt_ov = 0; cnt_ir = 0;
    for (int i = 0; i < 100; i++) begin
      a_iv = 1'b0;
      a_ordy = $urandom_range(1, 0) == 1;
      @(negedge clk);
      if (a_ov) cnt_ov++;
      if (a_ir) cnt_ir++;
      @(posedge clk); #1;
    end
    a_ordy = 1'b0;
    chk("idle_ov", cnt_ov, 0);
    chk("idle_ir", cnt_ir, 100);

    b_rst = 1'b0;
    for (int i = 0; i < 8; i++) bw[i] = int'($urandom_range(100)) - 50;
    for (int i = 0; i < 4; i++) bx[i] = int'($urandom_range(100)) - 50;
    idx = 0; nres = 0; cyc = 0; tx = -1; ne = 0; cb = 0; novc = 0;
    bres = '{0, 0};
    ovc = '{-100, -100};
    b_ordy = 1'b1;
    while (nres < 2 && cyc < 500) begin
      b_iv  = idx < 12;
      b_din = (idx < 8) ? bw[idx] : ((idx < 12) ? bx[idx-8] : 0);
      @(negedge clk);
      if (b_xwe && b_xa == 2'd3) tx = cyc;
      if (b_en) begin
        if (b_clr != (ne % 4 == 0)) cb++;
        ne++;
      end else if (b_clr) cb++;
      if (b_ov) begin
        if (novc < 2) ovc[novc] = cyc;
        novc++;
      end
      if (b_iv && b_ir) idx++;
      if (b_ov && b_ordy) begin
        bres[nres] = b_acc;
        nres++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    b_iv = 1'b0;
    chk("b_nres", nres, 2);
    for (int r = 0; r < 2; r++) begin
      e = 0;
      for (int c = 0; c < 4; c++) e += bw[r*4+c] * bx[c];
      chk($sformatf("b_y%0d", r), bres[r], e);
    end
    chk("b_lat_row0", ovc[0] - tx - 1, 7);
    chk("b_lat_row1", ovc[1] - ovc[0] - 1, 7);
    chk("b_ov_cycles", novc, 2);
    chk("b_en_count", ne, 8);
    chk("b_clr_first_only", cb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
